// File: rtl/uart_tx_pkg.sv
// rtl/uart_tx_pkg.sv - shared state encodings, parity constants and frame length helper
package uart_tx_pkg;

   typedef logic [2:0] state_t;

   // Gray-style encoding: each legal transition flips a single bit where possible
   localparam state_t ST_IDLE   = 3'b000;
   localparam state_t ST_START  = 3'b001;
   localparam state_t ST_DATA   = 3'b011;
   localparam state_t ST_STOP   = 3'b010;
   localparam state_t ST_PARITY = 3'b110;

   localparam logic PAR_EVEN = 1'b0;
   localparam logic PAR_ODD  = 1'b1;

   function automatic int unsigned frame_len(input int unsigned data_width,
                                             input logic        par_en,
                                             input logic        stop2);
      return 32'd2 + data_width + {31'd0, par_en} + {31'd0, stop2};
   endfunction

endpackage

// File: rtl/uart_parity_calc.sv
// rtl/uart_parity_calc.sv - combinational even/odd parity of a captured UART word
module uart_parity_calc
   import uart_tx_pkg::*;
#(
   parameter int DATA_WIDTH = 8
) (
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  par_typ,
   output logic                  parity
);

   assign parity = (^data) ^ (par_typ == PAR_ODD);

endmodule

// File: rtl/uart_tx_ctrl_p.sv
// rtl/uart_tx_ctrl_p.sv - parametrised UART transmit FSM and serializer
module uart_tx_ctrl_p
   import uart_tx_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter bit LSB_FIRST  = 1'b1
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] P_DATA,
   input  logic                  Data_Valid,
   input  logic                  PAR_EN,
   input  logic                  PAR_TYP,
   input  logic                  STOP2,
   output logic                  TX_OUT,
   output logic                  busy,
   output logic                  ready,
   output logic                  tx_done
);

   localparam int CW = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

   state_t                state_q, state_d;
   logic [CW-1:0]         bit_cnt_q, bit_cnt_d;
   logic                  stop_cnt_q, stop_cnt_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic                  par_en_q, par_en_d;
   logic                  par_typ_q, par_typ_d;
   logic                  stop2_q, stop2_d;
   logic                  tx_q, tx_d;
   logic                  last_stop;
   logic                  accept;
   logic                  parity_bit;
   logic [CW-1:0]         bit_idx;

   uart_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_parity (
      .data    (data_q),
      .par_typ (par_typ_q),
      .parity  (parity_bit)
   );

   assign last_stop = (state_q == ST_STOP) && (!stop2_q || stop_cnt_q);
   assign accept    = Data_Valid && ready;
   assign TX_OUT    = tx_q;

   always_ff @(posedge CLK) begin
      if (!RST) begin
         state_q    <= ST_IDLE;
         bit_cnt_q  <= '0;
         stop_cnt_q <= 1'b0;
         data_q     <= '0;
         par_en_q   <= 1'b0;
         par_typ_q  <= 1'b0;
         stop2_q    <= 1'b0;
         tx_q       <= 1'b1;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         stop_cnt_q <= stop_cnt_d;
         data_q     <= data_d;
         par_en_q   <= par_en_d;
         par_typ_q  <= par_typ_d;
         stop2_q    <= stop2_d;
         tx_q       <= tx_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      stop_cnt_d = stop_cnt_q;
      data_d     = data_q;
      par_en_d   = par_en_q;
      par_typ_d  = par_typ_q;
      stop2_d    = stop2_q;
      case (state_q)
         ST_IDLE:   if (accept) state_d = ST_START;
         ST_START: begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
         end
         ST_DATA: begin
            if (bit_cnt_q == LAST_BIT) state_d = par_en_q ? ST_PARITY : ST_STOP;
            else                       bit_cnt_d = bit_cnt_q + 1'b1;
         end
         ST_PARITY: state_d = ST_STOP;
         ST_STOP: begin
            if (last_stop) begin
               state_d    = Data_Valid ? ST_START : ST_IDLE;
               stop_cnt_d = 1'b0;
            end else begin
               stop_cnt_d = 1'b1;
            end
         end
         default: begin
            state_d    = ST_IDLE;
            bit_cnt_d  = '0;
            stop_cnt_d = 1'b0;
         end
      endcase
      // Shadow config is only sampled on acceptance so mid-frame input changes are inert
      if (accept) begin
         data_d     = P_DATA;
         par_en_d   = PAR_EN;
         par_typ_d  = PAR_TYP;
         stop2_d    = STOP2;
         bit_cnt_d  = '0;
         stop_cnt_d = 1'b0;
      end
   end

   // TX_OUT is registered from the next state so the start bit lands one cycle after acceptance
   always_comb begin
      bit_idx = LSB_FIRST ? bit_cnt_d : (LAST_BIT - bit_cnt_d);
      case (state_d)
         ST_START:  tx_d = 1'b0;
         ST_DATA:   tx_d = data_q[bit_idx];
         ST_PARITY: tx_d = parity_bit;
         default:   tx_d = 1'b1;
      endcase
      busy    = (state_q != ST_IDLE);
      ready   = (state_q == ST_IDLE) || last_stop;
      tx_done = last_stop;
   end

endmodule

// File: tb/tb_uart_tx_ctrl_p.sv
// tb/tb_uart_tx_ctrl_p.sv - scoreboard bench for uart_tx_ctrl_p, LSB-first and MSB-first instances
module tb_uart_tx_ctrl_p;

   logic       CLK;
   logic       RST;
   logic [7:0] P_DATA;
   logic       Data_Valid;
   logic       PAR_EN;
   logic       PAR_TYP;
   logic       STOP2;
   logic       tx_a, busy_a, rdy_a, done_a;
   logic       tx_b, busy_b, rdy_b, done_b;

   int vectors;
   int miscompares;
   int cyc;

   typedef struct packed {
      logic tx_a;
      logic tx_b;
      logic busy;
      logic done;
      logic rdy;
   } exp_t;

   exp_t exp_q[$];
   bit   qa[$];
   bit   qb[$];
   bit   acc_seen;

   uart_tx_ctrl_p #(.DATA_WIDTH(8), .LSB_FIRST(1'b1)) u_lsb (
      .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
      .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2),
      .TX_OUT(tx_a), .busy(busy_a), .ready(rdy_a), .tx_done(done_a)
   );

   uart_tx_ctrl_p #(.DATA_WIDTH(8), .LSB_FIRST(1'b0)) u_msb (
      .CLK(CLK), .RST(RST), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
      .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP), .STOP2(STOP2),
      .TX_OUT(tx_b), .busy(busy_b), .ready(rdy_b), .tx_done(done_b)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic build_frame(input logic [7:0] d, input logic pe, input logic pt, input logic s2);
      qa.push_back(1'b0);
      qb.push_back(1'b0);
      for (int i = 0; i < 8; i++) begin
         qa.push_back(d[i]);
         qb.push_back(d[7-i]);
      end
      if (pe) begin
         qa.push_back((^d) ^ pt);
         qb.push_back((^d) ^ pt);
      end
      qa.push_back(1'b1);
      qb.push_back(1'b1);
      if (s2) begin
         qa.push_back(1'b1);
         qb.push_back(1'b1);
      end
   endtask

   // Reference model: the line is a queue of pending bits; the head is what is on the wire
   always @(posedge CLK) begin
      bit   acc;
      exp_t e;
      if (!RST) begin
         qa.delete();
         qb.delete();
         acc_seen = 1'b0;
      end else begin
         acc = Data_Valid && (qa.size() <= 1);
         if (qa.size() > 0) begin
            void'(qa.pop_front());
            void'(qb.pop_front());
         end
         if (acc) build_frame(P_DATA, PAR_EN, PAR_TYP, STOP2);
         acc_seen = acc;
      end
      e.tx_a = (qa.size() > 0) ? qa[0] : 1'b1;
      e.tx_b = (qb.size() > 0) ? qb[0] : 1'b1;
      e.busy = (qa.size() > 0);
      e.done = (qa.size() == 1);
      e.rdy  = (qa.size() <= 1);
      exp_q.push_back(e);
   end

   always @(negedge CLK) begin
      exp_t e;
      cyc++;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         vectors++;
         if ({tx_a, busy_a, done_a, rdy_a} !== {e.tx_a, e.busy, e.done, e.rdy}) begin
            miscompares++;
            $display("FAIL lsb cyc=%0d got tx/busy/done/rdy=%b%b%b%b exp=%b%b%b%b",
                     cyc, tx_a, busy_a, done_a, rdy_a, e.tx_a, e.busy, e.done, e.rdy);
         end
         vectors++;
         if ({tx_b, busy_b, done_b, rdy_b} !== {e.tx_b, e.busy, e.done, e.rdy}) begin
            miscompares++;
            $display("FAIL msb cyc=%0d got tx/busy/done/rdy=%b%b%b%b exp=%b%b%b%b",
                     cyc, tx_b, busy_b, done_b, rdy_b, e.tx_b, e.busy, e.done, e.rdy);
         end
      end
   end

   task automatic idle(input int n);
      repeat (n) @(negedge CLK);
   endtask

   task automatic send(input logic [7:0] d, input logic pe, input logic pt, input logic s2, input bit keep);
      int n;
      P_DATA     = d;
      PAR_EN     = pe;
      PAR_TYP    = pt;
      STOP2      = s2;
      Data_Valid = 1'b1;
      n = 0;
      do begin
         @(posedge CLK);
         @(negedge CLK);
         n++;
      end while (!acc_seen && n < 40);
      if (!acc_seen) begin
         vectors++;
         miscompares++;
         $display("FAIL accept_timeout data=%h got no acceptance after %0d cycles, required acceptance", d, n);
      end
      if (!keep) Data_Valid = 1'b0;
   endtask

   initial begin
      vectors     = 0;
      miscompares = 0;
      cyc         = 0;
      RST         = 1'b0;
      P_DATA      = 8'h00;
      Data_Valid  = 1'b0;
      PAR_EN      = 1'b0;
      PAR_TYP     = 1'b0;
      STOP2       = 1'b0;
      idle(3);
      RST = 1'b1;
      idle(2);

      send(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
      idle(14);
      send(8'hA5, 1'b1, 1'b1, 1'b1, 1'b0);
      idle(14);
      send(8'h80, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(12);

      // back-to-back: valid held across both frames
      send(8'h55, 1'b0, 1'b0, 1'b0, 1'b1);
      send(8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(13);

      // mid-frame valid pulse and data change must not disturb the frame
      send(8'h3C, 1'b1, 1'b0, 1'b1, 1'b0);
      idle(2);
      P_DATA = 8'hFF; PAR_EN = 1'b0; STOP2 = 1'b0; Data_Valid = 1'b1;
      idle(1);
      Data_Valid = 1'b0;
      idle(3);
      P_DATA = 8'h00;
      idle(10);

      // reset during data bit 3
      send(8'hC3, 1'b1, 1'b1, 1'b0, 1'b0);
      idle(4);
      RST = 1'b0;
      idle(1);
      RST = 1'b1;
      idle(3);
      send(8'h96, 1'b1, 1'b0, 1'b1, 1'b0);
      idle(14);

      for (int f = 0; f < 150; f++) begin
         logic [7:0] d;
         bit keep;
         d    = 8'($urandom);
         keep = ($urandom_range(0, 2) == 0);
         send(d, 1'($urandom), 1'($urandom), 1'($urandom), keep);
         if (!keep) begin
            if ($urandom_range(0, 3) == 0) begin
               idle(2);
               P_DATA = 8'($urandom); PAR_EN = 1'($urandom); Data_Valid = 1'b1;
               idle(1);
               Data_Valid = 1'b0;
            end
            idle($urandom_range(0, 14));
         end
      end
      Data_Valid = 1'b0;
      idle(20);

      if (vectors == 0) begin
         miscompares++;
         $display("FAIL no_vectors got 0 compared cycles, required >0");
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/uart_tx_ctrl_p.md
Name: uart_tx_ctrl_p

Overview:
Parametrised UART transmit controller and serializer for the UART TX clock domain. It is the next generation of the fixed 8-bit TX FSM: it adds a data width parameter, selectable bit order, odd/even parity, 1 or 2 stop bits, and an internal bit counter instead of an external ser_done. It supports back-to-back frames with no idle gap, and sits between the async FIFO read side and the TX pin.

Parameters:
DATA_WIDTH, 8, payload bits per frame (5..9 legal).
LSB_FIRST, 1, 1 = bit 0 sent first, 0 = MSB first.

Ports:
CLK  input  1  UART TX clock; one serial bit per cycle.
RST  input  1  reset: synchronous, active-low.
P_DATA  input  DATA_WIDTH  parallel payload.
Data_Valid  input  1  payload valid; accepted only when ready=1.
PAR_EN  input  1  1 = append parity bit.
PAR_TYP  input  1  0 = even, 1 = odd.
STOP2  input  1  1 = two stop bits.
TX_OUT  output  1  serial line, registered, idle high.
busy  output  1  high for every cycle of a frame.
ready  output  1  combinational; high in IDLE or in the last stop cycle.
tx_done  output  1  one-cycle pulse in the last stop cycle of each frame.

Behaviour:
- Reset (RST=0 at a CLK edge) values: TX_OUT=1, busy=0, tx_done=0, state=IDLE, counters=0, data/config regs=0.
- Reset mid-frame aborts the frame; the line returns high at that edge and no partial bits follow.
- Acceptance: edge with Data_Valid=1 and ready=1.
  - Captures P_DATA, PAR_EN, PAR_TYP and STOP2 into shadow regs.
  - Input changes during a frame have no effect.
- Data_Valid while ready=0 is ignored, not queued. The source holds it until accepted.
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE -> START on acceptance.
  - START -> DATA after 1 cycle.
  - DATA -> PARITY (PAR_EN) or STOP after DATA_WIDTH cycles.
  - PARITY -> STOP after 1 cycle.
  - STOP lasts 1 cycle (STOP2=0) or 2 cycles (STOP2=1).
  - From the last STOP cycle: -> START if Data_Valid, else -> IDLE.
- TX_OUT timing: the start bit (0) appears in the cycle after the accepting edge, i.e. 1-cycle latency.
- Per-state TX_OUT:
  - DATA: captured bits, LSB or MSB first per LSB_FIRST.
  - PARITY: XOR of the captured data, inverted when PAR_TYP=1.
  - STOP: 1.
- Frame length = 1 + DATA_WIDTH + PAR_EN + 1 + STOP2 cycles.
- busy is high exactly over the frame cycles. Between back-to-back frames it stays continuously high, and a START immediately follows the last STOP.
- Bit counter width is $clog2(DATA_WIDTH). It clears on entering DATA and never wraps within a frame. The DATA exit is at count == DATA_WIDTH-1.
- The stop counter is 1 bit.
- Illegal state encodings recover to IDLE with TX_OUT=1 on the next edge.
- Parity is computed from the captured data, never from live P_DATA.

Decomposition:
- Package uart_tx_pkg:
  - state localparams, Gray-style: IDLE 3'b000, START 3'b001, DATA 3'b011, STOP 3'b010, PARITY 3'b110;
  - PAR_EVEN/PAR_ODD constants;
  - a frame_len function.
- Sub-module uart_parity_calc #(DATA_WIDTH): combinational parity of the captured word and PAR_TYP. It is also reused by the RX checker.
- FSM, shift/select and counters stay in uart_tx_ctrl_p.

Test Plan:
1. DATA_WIDTH=8, P_DATA=0xA5, PAR_EN=1, PAR_TYP=0, STOP2=0, single Data_Valid pulse -> TX_OUT = 0,1,0,1,0,0,1,0,1,0,1 (11 cycles). busy high for 11 cycles, tx_done on cycle 11, then idle high.
2. Same data with PAR_TYP=1, STOP2=1 -> parity bit 1, two stop 1s, 12-cycle frame.
3. PAR_EN=0, LSB_FIRST=0, P_DATA=0x80 -> 0,1,0,0,0,0,0,0,0,1 (10 cycles).
4. Data_Valid held with 0x55 then 0x0F -> the second START immediately follows the first STOP, busy never drops, 2 tx_done pulses 10 cycles apart.
5. Data_Valid pulsed mid-frame, and P_DATA changed mid-frame -> no effect on the current frame, no extra frame.
6. RST=0 during the DATA bit 3 cycle -> at that edge TX_OUT=1, busy=0, tx_done=0. A new Data_Valid after release sends a full clean frame.
